// File: rtl/alu_opb_stage_if.sv
// Bus bundle for the ALU operand-B stage: decode-side inputs, writeback
// candidates and the registered operand/forwarding outputs.
interface alu_opb_stage_if #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) ();
    logic              in_valid;
    logic              stall;
    logic              flush;
    logic [1:0]        srcb_sel;
    logic [REG_AW-1:0] rs2_addr;
    logic [DATA_W-1:0] rs2_dout;
    logic [IMM_W-1:0]  imm;
    logic              exmem_we;
    logic [REG_AW-1:0] exmem_rd;
    logic [DATA_W-1:0] exmem_data;
    logic              memwb_we;
    logic [REG_AW-1:0] memwb_rd;
    logic [DATA_W-1:0] memwb_data;
    logic [DATA_W-1:0] alu_opb;
    logic              opb_valid;
    logic [1:0]        fwd_sel;
    logic [CNT_W-1:0]  fwd_cnt;

    modport master (
        output in_valid, stall, flush, srcb_sel, rs2_addr, rs2_dout, imm,
        output exmem_we, exmem_rd, exmem_data, memwb_we, memwb_rd, memwb_data,
        input  alu_opb, opb_valid, fwd_sel, fwd_cnt
    );

    modport slave (
        input  in_valid, stall, flush, srcb_sel, rs2_addr, rs2_dout, imm,
        input  exmem_we, exmem_rd, exmem_data, memwb_we, memwb_rd, memwb_data,
        output alu_opb, opb_valid, fwd_sel, fwd_cnt
    );
endinterface

// File: rtl/alu_opb_stage.sv
// Selects ALU operand B (forwarded register or extended immediate) and registers it.
// Latency: one cycle from decode inputs to registered alu_opb/opb_valid/fwd_sel.
// Backpressure: stall holds all state, flush inserts a bubble and wins over stall.
module alu_opb_stage #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    alu_opb_stage_if.slave    bus
);
    localparam int EXT_W = DATA_W - IMM_W;

    localparam logic [1:0] SEL_REG  = 2'b00;
    localparam logic [1:0] SEL_SEXT = 2'b01;
    localparam logic [1:0] SEL_ZEXT = 2'b10;
    localparam logic [1:0] SEL_LUI  = 2'b11;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    logic              ex_hit;
    logic              wb_hit;
    logic [DATA_W-1:0] opnd_nxt;
    logic [1:0]        fsel_nxt;

    logic [DATA_W-1:0] opb_d,  opb_q;
    logic              vld_d,  vld_q;
    logic [1:0]        fsel_d, fsel_q;
    logic [CNT_W-1:0]  cnt_d,  cnt_q;

    // A non-zero rd match also rules out forwarding for rs2_addr == 0.
    always_comb begin
        ex_hit = bus.exmem_we && (bus.exmem_rd != '0) && (bus.exmem_rd == bus.rs2_addr);
        wb_hit = bus.memwb_we && (bus.memwb_rd != '0) && (bus.memwb_rd == bus.rs2_addr);
    end

    always_comb begin
        opnd_nxt = bus.rs2_dout;
        fsel_nxt = FWD_NONE;
        case (bus.srcb_sel)
            SEL_SEXT: opnd_nxt = {{EXT_W{bus.imm[IMM_W-1]}}, bus.imm};
            SEL_ZEXT: opnd_nxt = {{EXT_W{1'b0}}, bus.imm};
            SEL_LUI:  opnd_nxt = {bus.imm, {EXT_W{1'b0}}};
            default: begin
                if (ex_hit) begin
                    opnd_nxt = bus.exmem_data;
                    fsel_nxt = FWD_EXMEM;
                end else if (wb_hit) begin
                    opnd_nxt = bus.memwb_data;
                    fsel_nxt = FWD_MEMWB;
                end
            end
        endcase
    end

    always_comb begin
        opb_d  = opb_q;
        vld_d  = vld_q;
        fsel_d = fsel_q;
        cnt_d  = cnt_q;
        if (bus.flush) begin
            opb_d  = '0;
            vld_d  = 1'b0;
            fsel_d = FWD_NONE;
        end else if (!bus.stall) begin
            vld_d = bus.in_valid;
            if (bus.in_valid) begin
                opb_d  = opnd_nxt;
                fsel_d = fsel_nxt;
                // Counter sticks at all-ones instead of wrapping.
                if ((fsel_nxt != FWD_NONE) && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                opb_d  = '0;
                fsel_d = FWD_NONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opb_q  <= '0;
            vld_q  <= 1'b0;
            fsel_q <= FWD_NONE;
            cnt_q  <= '0;
        end else begin
            opb_q  <= opb_d;
            vld_q  <= vld_d;
            fsel_q <= fsel_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.alu_opb   = opb_q;
    assign bus.opb_valid = vld_q;
    assign bus.fwd_sel   = fsel_q;
    assign bus.fwd_cnt   = cnt_q;
endmodule

// File: doc/alu_opb_stage.md
ALU_OPB_STAGE -- requirements
Module: alu_opb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/data width (>= 17).
REQ-002 SHALL have parameter IMM_W, default 16, immediate field width (< DATA_W).
REQ-003 SHALL have parameter REG_AW, default 5, register address width.
REQ-004 SHALL have parameter CNT_W, default 16, forwarding event counter width.
REQ-005 SHALL have ports, clock and reset first (one clock; reset is asynchronous and active-high):
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decode-stage instruction valid
- stall  in  1  hold stage contents
- flush  in  1  insert bubble
- srcb_sel  in  2  00 register, 01 sign-ext imm, 10 zero-ext imm, 11 imm shifted up by IMM_W (LUI)
- rs2_addr  in  REG_AW  source register B address
- rs2_dout  in  DATA_W  register file read data B
- imm  in  IMM_W  raw immediate
- exmem_we, exmem_rd, exmem_data  in  1/REG_AW/DATA_W  EX/MEM writeback candidate
- memwb_we, memwb_rd, memwb_data  in  1/REG_AW/DATA_W  MEM/WB writeback candidate
- alu_opb  out  DATA_W  registered operand B
- opb_valid  out  1  registered valid
- fwd_sel  out  2  registered source: 00 none, 01 EX/MEM, 10 MEM/WB
- fwd_cnt  out  CNT_W  saturating count of forwarded operands

Function
REQ-006 SHALL compute next operand combinationally: sel 01 -> imm sign-extended to DATA_W; 10 -> imm zero-extended; 11 -> imm in bits [DATA_W-1 : DATA_W-IMM_W], low bits zero; 00 -> forwarded register value.
REQ-007 SHALL, for sel 00, pick exmem_data when exmem_we=1, exmem_rd!=0, exmem_rd==rs2_addr.
REQ-008 SHALL otherwise, for sel 00, pick memwb_data when memwb_we=1, memwb_rd!=0, memwb_rd==rs2_addr.
REQ-009 SHALL otherwise pick rs2_dout; EX/MEM has priority over MEM/WB on simultaneous match.
REQ-010 SHALL never forward for rs2_addr==0 nor when srcb_sel!=00; next fwd_sel=00 then.
REQ-011 SHALL, on rising clk with flush=1, clear alu_opb, opb_valid and fwd_sel to 0; flush wins over stall.
REQ-012 SHALL, on rising clk with stall=1, flush=0, hold alu_opb, opb_valid, fwd_sel, fwd_cnt.
REQ-013 SHALL, on rising clk with stall=0, flush=0, load opb_valid<=in_valid; if in_valid=1 load alu_opb and fwd_sel from REQ-006..010, else load both as 0.
REQ-014 SHALL have latency one cycle: inputs at edge N appear on outputs after edge N.
REQ-015 SHALL increment fwd_cnt by 1 only on a load (REQ-013) with in_valid=1 and next fwd_sel!=00.
REQ-016 SHALL saturate fwd_cnt at 2^CNT_W-1; no wrap to 0.
REQ-017 SHALL not change fwd_cnt on flush or stall cycles.
REQ-018 SHALL treat all data as unsigned bit vectors; no arithmetic other than the counter.

Reset
REQ-019 SHALL, while rst=1, immediately force alu_opb=0, opb_valid=0, fwd_sel=00, fwd_cnt=0, independent of clk.
REQ-020 SHALL, on rst assertion mid-operation (stall or in-flight valid), discard stage contents; first load follows first rising clk after rst deasserts.

Verification
REQ-021 SHALL pass: sel=01, imm=0x8001, in_valid=1 -> next cycle alu_opb=0xFFFF8001, opb_valid=1, fwd_sel=00.
REQ-022 SHALL pass: sel=11, imm=0x1234 -> alu_opb=0x12340000; sel=10, imm=0x8001 -> alu_opb=0x00008001.
REQ-023 SHALL pass: sel=00, rs2_addr=5, exmem (1,5,0xAAAA0000) and memwb (1,5,0xBBBB0000) -> alu_opb=0xAAAA0000, fwd_sel=01, fwd_cnt+1; rs2_addr=0 with both matching rd=0 -> alu_opb=rs2_dout, fwd_sel=00, count unchanged.
REQ-024 SHALL pass: load value X, then stall=1 for 3 cycles with changed inputs -> outputs hold X; stall=1 and flush=1 together -> opb_valid=0, alu_opb=0.
REQ-025 SHALL pass: CNT_W=2, 5 consecutive forwarded loads -> fwd_cnt sequence 1,2,3,3,3.
REQ-026 SHALL pass: rst asserted between clock edges with opb_valid=1 -> all outputs 0 before next edge.
